// File: rtl/bp_pkg.sv
// bp_pkg: shared predictor widths and counter constants.
// Used by the bimodal predictor and bp_resolve_queue.
package bp_pkg;
   localparam int INDEX_BITS_DEF = 8;
   localparam int PC_W_DEF = 32;
   localparam logic [1:0] CTR_WNT = 2'b01;
   function automatic int entry_w(input int index_bits, input int pc_w);
      return index_bits + 1 + pc_w;
   endfunction
endpackage

// File: rtl/bp_resolve_queue_if.sv
// bp_resolve_queue_if: fetch alloc, EX resolve, flush and PHT update/redirect signals.
// master drives alloc_*/resolve_*/flush; slave (the queue) drives
// alloc_ready, update_*, mispredict, redirect_pc, count and underflow.
interface bp_resolve_queue_if #(
   parameter int INDEX_BITS = 8,
   parameter int PC_W = 32,
   parameter int DEPTH = 4
);
   logic                    alloc_valid;
   logic [INDEX_BITS-1:0]   alloc_index;
   logic                    alloc_pred_taken;
   logic [PC_W-1:0]         alloc_fallthru_pc;
   logic                    alloc_ready;
   logic                    resolve_valid;
   logic                    resolve_taken;
   logic [PC_W-1:0]         resolve_target;
   logic                    flush;
   logic                    update_en;
   logic [INDEX_BITS-1:0]   update_index;
   logic                    update_taken;
   logic                    mispredict;
   logic [PC_W-1:0]         redirect_pc;
   logic [$clog2(DEPTH):0]  count;
   logic                    underflow;
   modport master (
      output alloc_valid, alloc_index, alloc_pred_taken, alloc_fallthru_pc,
             resolve_valid, resolve_taken, resolve_target, flush,
      input  alloc_ready, update_en, update_index, update_taken, mispredict,
             redirect_pc, count, underflow
   );
   modport slave (
      input  alloc_valid, alloc_index, alloc_pred_taken, alloc_fallthru_pc,
             resolve_valid, resolve_taken, resolve_target, flush,
      output alloc_ready, update_en, update_index, update_taken, mispredict,
             redirect_pc, count, underflow
   );
endinterface

// File: rtl/bp_entry_fifo.sv
// bp_entry_fifo: circular buffer of in-flight branch entries.
// Ports: clk, reset; i_push/i_wdata write at tail (ignored when full);
// i_pop advances head (ignored when empty); i_clear empties the buffer
// and overrides push/pop; o_rdata is the head entry; o_count/o_full/o_empty status.
module bp_entry_fifo #(
   parameter int W = 41,
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   i_push,
   input  logic                   i_pop,
   input  logic                   i_clear,
   input  logic [W-1:0]           i_wdata,
   output logic [W-1:0]           o_rdata,
   output logic [$clog2(DEPTH):0] o_count,
   output logic                   o_full,
   output logic                   o_empty
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   logic [W-1:0]  r_mem [DEPTH];
   logic [PW-1:0] r_head;
   logic [PW-1:0] r_tail;
   logic [CW-1:0] r_count;
   logic          w_push;
   logic          w_pop;
   assign o_full  = r_count == CW'(DEPTH);
   assign o_empty = r_count == '0;
   assign w_push  = i_push && !o_full && !i_clear;
   assign w_pop   = i_pop && !o_empty && !i_clear;
   assign o_rdata = r_mem[r_head];
   assign o_count = r_count;
   always_ff @(posedge clk) begin
      if (reset || i_clear) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_tail <= r_tail + 1'b1;
         if (w_pop) r_head <= r_head + 1'b1;
         r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
   end
   always_ff @(posedge clk)
      if (w_push) r_mem[r_tail] <= i_wdata;
endmodule

// File: rtl/bp_resolve_queue.sv
// bp_resolve_queue: tracks predicted branches from IF until EX resolves them,
// then issues the registered PHT update and mispredict redirect.
// Ports: clk, reset (sync, active-high); bus (slave) carries the fetch
// allocation, EX resolution, flush, PHT update and redirect signals.
module bp_resolve_queue
   import bp_pkg::*;
#(
   parameter int INDEX_BITS = INDEX_BITS_DEF,
   parameter int PC_W = PC_W_DEF,
   parameter int DEPTH = 4
) (
   input logic              clk,
   input logic              reset,
   bp_resolve_queue_if.slave bus
);
   localparam int EW = entry_w(INDEX_BITS, PC_W);
   logic [EW-1:0]          w_head;
   logic [INDEX_BITS-1:0]  w_head_index;
   logic                   w_head_pred;
   logic [PC_W-1:0]        w_head_fpc;
   logic [$clog2(DEPTH):0] w_count;
   logic                   w_full;
   logic                   w_empty;
   logic                   w_resolve;
   logic                   w_mis;
   logic                   r_update_en;
   logic [INDEX_BITS-1:0]  r_update_index;
   logic                   r_update_taken;
   logic                   r_mispredict;
   logic [PC_W-1:0]        r_redirect_pc;
   logic                   r_underflow;
   assign {w_head_index, w_head_pred, w_head_fpc} = w_head;
   // flush suppresses resolution entirely; a mispredict clears all younger entries
   assign w_resolve = bus.resolve_valid && !w_empty && !bus.flush;
   assign w_mis     = w_resolve && (w_head_pred != bus.resolve_taken);
   bp_entry_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_push  (bus.alloc_valid),
      .i_pop   (w_resolve),
      .i_clear (bus.flush || w_mis),
      .i_wdata ({bus.alloc_index, bus.alloc_pred_taken, bus.alloc_fallthru_pc}),
      .o_rdata (w_head),
      .o_count (w_count),
      .o_full  (w_full),
      .o_empty (w_empty)
   );
   always_ff @(posedge clk) begin
      if (reset) begin
         r_update_en    <= 1'b0;
         r_update_index <= '0;
         r_update_taken <= 1'b0;
         r_mispredict   <= 1'b0;
         r_redirect_pc  <= '0;
         r_underflow    <= 1'b0;
      end else begin
         r_update_en  <= w_resolve;
         r_mispredict <= w_mis;
         if (w_resolve) begin
            r_update_index <= w_head_index;
            r_update_taken <= bus.resolve_taken;
         end
         if (w_mis) r_redirect_pc <= bus.resolve_taken ? bus.resolve_target : w_head_fpc;
         if (bus.resolve_valid && w_empty) r_underflow <= 1'b1;
      end
   end
   assign bus.alloc_ready  = !w_full;
   assign bus.update_en    = r_update_en;
   assign bus.update_index = r_update_index;
   assign bus.update_taken = r_update_taken;
   assign bus.mispredict   = r_mispredict;
   assign bus.redirect_pc  = r_redirect_pc;
   assign bus.count        = w_count;
   assign bus.underflow    = r_underflow;
endmodule

// File: tb/tb_bp_resolve_queue.sv
// tb_bp_resolve_queue: directed vector table plus reset sequences for bp_resolve_queue.
module tb_bp_resolve_queue;
   typedef struct {
      logic        av;
      logic [7:0]  ai;
      logic        ap;
      logic [31:0] afp;
      logic        rv;
      logic        rt;
      logic [31:0] tg;
      logic        fl;
      logic        ue;
      logic [7:0]  ui;
      logic        ut;
      logic        mp;
      logic [31:0] rpc;
      logic [2:0]  cnt;
      logic        rdy;
      logic        uf;
   } vec_t;
   logic clk = 1'b0;
   logic reset;
   int   n_tests = 0;
   int   n_fail = 0;
   vec_t v[$];
   bp_resolve_queue_if #(.INDEX_BITS(8), .PC_W(32), .DEPTH(4)) bus ();
   bp_resolve_queue #(.INDEX_BITS(8), .PC_W(32), .DEPTH(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );
   always #5 clk = ~clk;
   function automatic vec_t mk(
      input logic av, input logic [7:0] ai, input logic ap, input logic [31:0] afp,
      input logic rv, input logic rt, input logic [31:0] tg, input logic fl,
      input logic ue, input logic [7:0] ui, input logic ut, input logic mp,
      input logic [31:0] rpc, input logic [2:0] cnt, input logic rdy, input logic uf);
      vec_t r;
      r = '{av, ai, ap, afp, rv, rt, tg, fl, ue, ui, ut, mp, rpc, cnt, rdy, uf};
      return r;
   endfunction
   function automatic logic [47:0] outs();
      return {bus.update_en, bus.update_index, bus.update_taken, bus.mispredict,
              bus.redirect_pc, bus.count, bus.alloc_ready, bus.underflow};
   endfunction
   task automatic drive(input vec_t x);
      bus.alloc_valid       = x.av;
      bus.alloc_index       = x.ai;
      bus.alloc_pred_taken  = x.ap;
      bus.alloc_fallthru_pc = x.afp;
      bus.resolve_valid     = x.rv;
      bus.resolve_taken     = x.rt;
      bus.resolve_target    = x.tg;
      bus.flush             = x.fl;
   endtask
   task automatic check(input string name, input logic [47:0] got, input logic [47:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got {ue,ui,ut,mp,rpc,cnt,rdy,uf}=%h expected %h", name, got, exp);
      end
   endtask
   localparam logic [47:0] RESET_OUTS = {1'b0, 8'h00, 1'b0, 1'b0, 32'h0, 3'd0, 1'b1, 1'b0};
   initial begin
      vec_t idle;
      idle = mk(0, 8'h00, 0, 32'h0, 0, 0, 32'h0, 0, 0, 8'h00, 0, 0, 32'h0, 3'd0, 1, 0);
      drive(idle);
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      check("reset_state", outs(), RESET_OUTS);
      //         av ai    ap afp        rv rt tg         fl   ue ui    ut mp rpc        cnt rdy uf
      v.push_back(mk(1, 8'h12, 0, 32'h104, 0, 0, 32'h0,   0,   0, 8'h00, 0, 0, 32'h0,   3'd1, 1, 0));
      v.push_back(mk(0, 8'h00, 0, 32'h0,   1, 0, 32'h999, 0,   1, 8'h12, 0, 0, 32'h0,   3'd0, 1, 0));
      v.push_back(mk(0, 8'h00, 0, 32'h0,   0, 0, 32'h0,   0,   0, 8'h12, 0, 0, 32'h0,   3'd0, 1, 0));
      v.push_back(mk(1, 8'h20, 0, 32'h200, 0, 0, 32'h0,   0,   0, 8'h12, 0, 0, 32'h0,   3'd1, 1, 0));
      v.push_back(mk(1, 8'h21, 1, 32'h300, 0, 0, 32'h0,   0,   0, 8'h12, 0, 0, 32'h0,   3'd2, 1, 0));
      v.push_back(mk(0, 8'h00, 0, 32'h0,   1, 1, 32'h400, 0,   1, 8'h20, 1, 1, 32'h400, 3'd0, 1, 0));
      v.push_back(mk(0, 8'h00, 0, 32'h0,   0, 0, 32'h0,   0,   0, 8'h20, 1, 0, 32'h400, 3'd0, 1, 0));
      v.push_back(mk(1, 8'h30, 1, 32'ha0,  0, 0, 32'h0,   0,   0, 8'h20, 1, 0, 32'h400, 3'd1, 1, 0));
      v.push_back(mk(1, 8'h31, 0, 32'hb0,  0, 0, 32'h0,   0,   0, 8'h20, 1, 0, 32'h400, 3'd2, 1, 0));
      v.push_back(mk(1, 8'h32, 1, 32'hc0,  0, 0, 32'h0,   0,   0, 8'h20, 1, 0, 32'h400, 3'd3, 1, 0));
      v.push_back(mk(1, 8'h33, 0, 32'hd0,  0, 0, 32'h0,   0,   0, 8'h20, 1, 0, 32'h400, 3'd4, 0, 0));
      v.push_back(mk(1, 8'h34, 1, 32'he0,  0, 0, 32'h0,   0,   0, 8'h20, 1, 0, 32'h400, 3'd4, 0, 0));
      v.push_back(mk(0, 8'h00, 0, 32'h0,   1, 1, 32'h111, 0,   1, 8'h30, 1, 0, 32'h400, 3'd3, 1, 0));
      v.push_back(mk(0, 8'h00, 0, 32'h0,   1, 0, 32'h111, 0,   1, 8'h31, 0, 0, 32'h400, 3'd2, 1, 0));
      v.push_back(mk(0, 8'h00, 0, 32'h0,   1, 1, 32'h111, 0,   1, 8'h32, 1, 0, 32'h400, 3'd1, 1, 0));
      v.push_back(mk(0, 8'h00, 0, 32'h0,   1, 0, 32'h111, 0,   1, 8'h33, 0, 0, 32'h400, 3'd0, 1, 0));
      v.push_back(mk(1, 8'h40, 0, 32'h400, 0, 0, 32'h0,   0,   0, 8'h33, 0, 0, 32'h400, 3'd1, 1, 0));
      v.push_back(mk(1, 8'h41, 1, 32'h410, 0, 0, 32'h0,   0,   0, 8'h33, 0, 0, 32'h400, 3'd2, 1, 0));
      v.push_back(mk(1, 8'h42, 0, 32'h420, 1, 0, 32'h0,   0,   1, 8'h40, 0, 0, 32'h400, 3'd2, 1, 0));
      v.push_back(mk(1, 8'h43, 1, 32'h430, 1, 0, 32'h555, 0,   1, 8'h41, 0, 1, 32'h410, 3'd0, 1, 0));
      v.push_back(mk(1, 8'h50, 1, 32'h500, 0, 0, 32'h0,   0,   0, 8'h41, 0, 0, 32'h410, 3'd1, 1, 0));
      v.push_back(mk(1, 8'h51, 0, 32'h510, 1, 0, 32'h777, 1,   0, 8'h41, 0, 0, 32'h410, 3'd0, 1, 0));
      v.push_back(mk(0, 8'h00, 0, 32'h0,   1, 1, 32'h888, 0,   0, 8'h41, 0, 0, 32'h410, 3'd0, 1, 1));
      v.push_back(mk(1, 8'h60, 0, 32'h600, 0, 0, 32'h0,   0,   0, 8'h41, 0, 0, 32'h410, 3'd1, 1, 1));
      v.push_back(mk(0, 8'h00, 0, 32'h0,   0, 0, 32'h0,   0,   0, 8'h41, 0, 0, 32'h410, 3'd1, 1, 1));
      foreach (v[i]) begin
         drive(v[i]);
         @(posedge clk);
         #1 check($sformatf("vec%0d", i), outs(),
                  {v[i].ue, v[i].ui, v[i].ut, v[i].mp, v[i].rpc, v[i].cnt, v[i].rdy, v[i].uf});
      end
      // reset with an entry in flight and a resolve pending: no update, all cleared
      drive(mk(1, 8'h70, 1, 32'h700, 1, 1, 32'h999, 0, 0, 8'h00, 0, 0, 32'h0, 3'd0, 1, 0));
      reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      drive(idle);
      check("reset_midop", outs(), RESET_OUTS);
      // the dropped entry must not reappear: a resolve now finds the queue empty
      drive(mk(0, 8'h00, 0, 32'h0, 1, 0, 32'h0, 0, 0, 8'h00, 0, 0, 32'h0, 3'd0, 1, 0));
      @(posedge clk);
      #1 drive(idle);
      check("post_reset_empty_resolve", outs(),
            {1'b0, 8'h00, 1'b0, 1'b0, 32'h0, 3'd0, 1'b1, 1'b1});
      // alloc then correct resolve, then mispredict pulse is exactly one cycle
      drive(mk(1, 8'h81, 1, 32'h810, 0, 0, 32'h0, 0, 0, 8'h00, 0, 0, 32'h0, 3'd0, 1, 0));
      @(posedge clk);
      #1 drive(mk(0, 8'h00, 0, 32'h0, 1, 0, 32'hbeef, 0, 0, 8'h00, 0, 0, 32'h0, 3'd0, 1, 0));
      @(posedge clk);
      #1 drive(idle);
      check("mis_fallthru", outs(), {1'b1, 8'h81, 1'b0, 1'b1, 32'h810, 3'd0, 1'b1, 1'b1});
      @(posedge clk);
      #1 check("mis_one_cycle", outs(), {1'b0, 8'h81, 1'b0, 1'b0, 32'h810, 3'd0, 1'b1, 1'b1});
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
